// File: rtl/csa_accumulator.sv
// Carry-save accumulator: one 3:2 compression per accepted term, pair out on group close.
// Optional CSA_ACC_B2B_EN lets a new group start in the drain cycle.
module csa_accumulator #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [WIDTH-1:0]   out_carry,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   s;
  logic [WIDTH-1:0]   c;
  logic [COUNT_W-1:0] cnt;

  logic [WIDTH-1:0]   s_n;
  logic [WIDTH-1:0]   c_n;
  logic [COUNT_W-1:0] cnt_n;
  logic               drain;
  logic               accept;
  logic               flush;

  assign drain = (state == HOLD) && out_ready;

`ifdef CSA_ACC_B2B_EN
  assign in_ready = (state == ACC) || drain;
`else
  assign in_ready = (state == ACC);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    s_n   = s ^ c ^ in_data;
    c_n   = ((s & c) | (s & in_data) | (c & in_data)) << 1;
    cnt_n = cnt + CNT_ONE;
    flush = in_last || (cnt_n == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      s     <= '0;
      c     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            s   <= s_n;
            c   <= c_n;
            cnt <= cnt_n;
            if (flush) state <= HOLD;
          end
        end
        HOLD: begin
          if (drain) begin
`ifdef CSA_ACC_B2B_EN
            if (accept) begin
              // Drain-cycle term opens a fresh group
              s   <= in_data;
              c   <= '0;
              cnt <= CNT_ONE;
              if (in_last || (CNT_ONE == CNT_MAX))
                state <= HOLD;
              else
                state <= ACC;
            end else begin
              s     <= '0;
              c     <= '0;
              cnt   <= '0;
              state <= ACC;
            end
`else
            s     <= '0;
            c     <= '0;
            cnt   <= '0;
            state <= ACC;
`endif
          end
        end
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign out_sum   = s;
  assign out_carry = c;
  assign out_count = cnt;

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator (WIDTH=16, COUNT_W=4).
// Directed groups; monitor pops expected pairs on each output handshake.
module tb_csa_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [15:0] out_carry;
  logic [3:0]  out_count;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   fails;

  csa_accumulator #(.WIDTH(16), .COUNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] sum, input logic [3:0] cnt);
    exp_t e;
    e.sum = sum;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: data 0x%0h never accepted", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_group: sum 0x%0h count %0d, none expected",
                 16'(out_sum + out_carry), out_count);
      end else begin
        exp_t e;
        logic [15:0] tot;
        e   = q.pop_front();
        tot = out_sum + out_carry;
        check("group_sum", 32'(tot), 32'(e.sum));
        check("group_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cap_s;
    logic [15:0] cap_c;
    logic [3:0]  cap_n;
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);

    push(16'd60, 4'd3);
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    send(16'd30, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    idle(2);

    push(16'h0001, 4'd2);
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    idle(2);

    out_ready = 1'b0;
    push(16'd5, 4'd1);
    push(16'd7, 4'd1);
    send(16'd5, 1'b1);
    cap_s = out_sum;
    cap_c = out_carry;
    cap_n = out_count;
    check("hold_sum", 32'(16'(cap_s + cap_c)), 32'd5);
    check("hold_count", 32'(cap_n), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_stable_sum", 32'(out_sum), 32'(cap_s));
      check("hold_stable_carry", 32'(out_carry), 32'(cap_c));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
`ifdef CSA_ACC_B2B_EN
    check("drain_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("drain_b2b_valid", 32'(out_valid), 32'd1);
`else
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("drain_valid", 32'(out_valid), 32'd0);
    send(16'd7, 1'b1);
`endif
    idle(2);

    for (int i = 0; i < 15; i++) begin
      if (i == 14) push(16'd15, 4'd15);
      send(16'd1, 1'b0);
    end
    check("autoflush_valid", 32'(out_valid), 32'd1);
    idle(2);

    send(16'd9, 1'b0);
    send(16'd9, 1'b0);
    check("pre_rst_carry", 32'(out_carry), 32'd18);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_carry", 32'(out_carry), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    push(16'd5, 4'd1);
    send(16'd5, 1'b1);
    idle(2);

`ifdef CSA_ACC_B2B_EN
    out_ready = 1'b0;
    push(16'd3, 4'd1);
    send(16'd3, 1'b1);
    idle(1);
    check("b2b_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    push(16'd4, 4'd1);
    send(16'd4, 1'b1);
    check("b2b_no_idle", 32'(out_valid), 32'd1);
    idle(2);
`endif

    idle(4);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Sequential carry-save accumulator that produces the redundant operand pair consumed by `final_addition`. It accepts a stream of WIDTH-bit terms over a valid/ready handshake and compresses each term into registered sum and carry vectors with one 3:2 compression per cycle. On the last term of a group it presents the pair `{out_sum, out_carry}` over a second valid/ready handshake. Downstream, `final_addition` resolves the pair into the binary result.

## Interface
Parameters:
- WIDTH, 16: term width and width of each redundant output vector.
- COUNT_W, 4: width of the term counter; the maximum group size is 2^COUNT_W-1.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the term on in_data is valid.
- in_ready  output  1  the block accepts a term this cycle.
- in_data  input  WIDTH  term to accumulate; unsigned, modulo 2^WIDTH.
- in_last  input  1  the accepted term closes the group.
- out_valid  output  1  the redundant pair is valid.
- out_ready  input  1  downstream consumes the pair this cycle.
- out_sum  output  WIDTH  sum vector; connects to `final_addition.in1`.
- out_carry  output  WIDTH  carry vector; connects to `final_addition.in2`.
- out_count  output  COUNT_W  number of terms in the presented group.

## Operation
- State machine has two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset value of every register and output is 0, except in_ready, which is 1 (state ACC).
- Term accept occurs on in_valid && in_ready. With registers s, c, d=in_data:
  - s' = s ^ c ^ d
  - c' = ((s&c)|(s&d)|(c&d)) << 1, truncated to WIDTH bits.
  - count' = count+1.
- Invariant: (s + c) mod 2^WIDTH equals the sum of accepted terms mod 2^WIDTH. The bit shifted out of the carry vector's MSB is discarded. The `final_addition` output bit WIDTH is therefore not meaningful for group sums.
- Transition ACC->HOLD occurs on an accept when in_last=1 or count'=2^COUNT_W-1 (auto-flush).
- Transition HOLD->ACC occurs on out_ready=1. In the same edge, s, c and count clear to 0.
- In HOLD, out_sum, out_carry and out_count stay stable until the handshake completes. in_valid is ignored while in_ready=0.
- A zero-term group cannot occur; out_count is always ≥1 when out_valid=1.
- Reset asserted mid-group discards the partial group immediately.

## Timing
- Outputs are driven from registers only; there is no combinational path from inputs to out_*.
- in_ready depends only on state, except when CSA_ACC_B2B_EN is defined (see Configuration).
- Throughput: one term per cycle in ACC.
- Latency: if the last term is accepted at edge N, out_valid=1 after edge N.
- Group overhead: minimum 1 HOLD cycle per group without CSA_ACC_B2B_EN; 0 cycles with it.
- Simultaneous events in HOLD with out_ready=1 and in_valid=1: behaviour is defined by the macro below.

## Configuration
- Macro CSA_ACC_B2B_EN enables back-to-back groups.
- Defined:
  - In HOLD, in_ready = out_ready.
  - A term accepted in the drain cycle starts a new group: s'=in_data, c'=0, count'=1.
  - If that term has in_last=1 (or COUNT_W forces a flush), the state remains HOLD with the new pair.
- Undefined:
  - In HOLD, in_ready=0 unconditionally.
  - The first term of the next group is accepted no earlier than the cycle after the drain.

## Test plan
- Reset, then release with WIDTH=16, COUNT_W=4 -> out_valid=0, in_ready=1, out_sum=out_carry=0, out_count=0.
- Terms 10, 20, 30 with in_last on 30, out_ready=1 -> out_valid one cycle after 30 is accepted; (out_sum+out_carry) mod 2^16=60; out_count=3; `final_addition` low 16 bits=60.
- Terms 0xFFFF, 0x0002 (last) -> (out_sum+out_carry) mod 2^16=0x0001; out_count=2.
- Group 5 (last) with out_ready=0 for 5 cycles while in_valid=1 with data 7 -> out_valid held; out_* stable at sum 5; in_ready=0 (macro undefined); 7 accepted only after the drain.
- 15 terms of 1, never last -> auto-flush; out_valid after the 15th; sum 15; out_count=15. Also: rst_n pulsed low after 2 terms of 9 -> all outputs 0 immediately; a following group of 5 (last) -> sum 5, out_count=1.
- With CSA_ACC_B2B_EN: group 3 (last) in HOLD, then out_ready=1 together with in_valid=1, data 4, last=1 -> no idle cycle; out_valid stays 1; next pair sum 4, out_count=1.
